game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Parametrised game-flow controller: sequences IDLE → PLAY → FINISH with optional pause, generates the game tick from the system clock, runs the countdown timer and a saturating BCD score accumulator, and renders the status row (time and score as tile codes) for the 8×8 tile display. It sits at the top of the game hierarchy. `play_en` and `tick` drive the player and bubble managers, and `status_row` feeds display Row1.

## Interface
- `TICK_DIV`, 100_000_000, clk cycles per game tick (≥2)
- `GAME_TICKS`, 60, game duration in ticks (1..99)
- `SCORE_DIGITS`, 4, BCD score digits (1..5)
- `COLS`, 8, tiles per row. `SCORE_DIGITS + 3 ≤ COLS`
- `TILE_W`, 5, bits per tile code
- `clk` in 1 system clock. One clock domain.
- `rst` in 1 synchronous, active-high reset
- `en` in 1 start/restart request, level; the rising edge is used
- `pause` in 1 pause toggle, level; the rising edge is used
- `hit_valid` in 1 one-cycle score event
- `hit_pts` in 4 points for the event, 0..9; values >9 are clamped to 9
- `state` out 2 IDLE=0, PLAY=1, PAUSED=2, FINISH=3
- `play_en` out 1 high iff state==PLAY
- `tick` out 1 one-cycle game tick pulse; asserted only in PLAY
- `finished` out 1 high iff state==FINISH
- `time_left` out 7 remaining ticks, binary
- `score_bcd` out 4*SCORE_DIGITS BCD score, least significant digit lowest
- `status_row` out COLS*TILE_W tile codes; the leftmost tile is in the MSBs

## Operation
- Edge detect: registered `en_q` and `pause_q`. `en_rise = en & ~en_q`, and likewise for pause. `en_q` and `pause_q` reset to 0.
- FSM transitions:
  - IDLE –en_rise→ PLAY
  - PLAY –pause_rise→ PAUSED
  - PAUSED –pause_rise→ PLAY
  - PLAY –final tick→ FINISH
  - FINISH –en_rise→ PLAY
- `en_rise` in PLAY or PAUSED is ignored. A pause edge in IDLE or FINISH is ignored.
- Entering PLAY from IDLE or FINISH clears the score, loads `time_left`=GAME_TICKS, and clears the prescaler.
- Prescaler:
  - Counts 0..TICK_DIV-1 in PLAY only. Held in PAUSED and cleared otherwise.
  - `tick`=1 in the cycle the count equals TICK_DIV-1; the count wraps to 0.
- Timer:
  - Decrements on `tick`.
  - A tick with `time_left`==1 is the final tick: `time_left` becomes 0 and the state becomes FINISH on the same edge.
- Score:
  - Accepts `hit_valid` in PLAY only. Hits in IDLE, PAUSED or FINISH are dropped.
  - The BCD add ripples a carry across the digits.
  - The score saturates at all nines: any add that would overflow yields all 9s.
- Simultaneous events:
  - A hit and the final tick in the same cycle: the hit is counted.
  - A pause edge and the final tick in the same cycle: FINISH wins.
- `status_row` layout, from the left:
  - tile 0 and tile 1: tens and units digits of `time_left`
  - tile 2: DARK
  - remaining tiles: DARK padding, then the score digits right-aligned, most significant first
  - in IDLE, all tiles are DARK
  - digit d is coded as tile d; DARK is 31

## Timing
- Reset state: `state`=IDLE, `play_en`=0, `tick`=0, `finished`=0, `score_bcd`=0, `time_left`=GAME_TICKS, `status_row` all ones.
- `en_rise` sampled at edge N gives PLAY from edge N+1. The first tick comes TICK_DIV cycles after entering PLAY.
- State, score and timer update on the edge that samples their cause. All outputs are registered.
- `status_row` is combinational from the registered state, score and timer, so it has no added latency.
- Game length is exactly GAME_TICKS×TICK_DIV PLAY cycles; PAUSED cycles are excluded.
- `rst` mid-game returns to the reset state on the next edge and discards pending edges.

## Configuration
- `GAME_PAUSE_EN` defined: the pause path and the PAUSED state are built as described.
- `GAME_PAUSE_EN` undefined: `pause` is ignored, PAUSED is unreachable and not synthesised, and `state` never equals 2.

## Structure
- Package `game_pkg` holds:
  - the state enum (IDLE, PLAY, PAUSED, FINISH)
  - `TILE_DARK`=5'd31 and `TILE_DIGIT0`=5'd0
  - the shared `TILE_W` constant
- Sub-module `bcd_accum`, parameter DIGITS: synchronous clear, add of a 4-bit value with ripple carry, saturation at all 9s.
- The FSM, prescaler, timer and row encoder stay in `game_flow_ctrl`.

## Test plan
All scenarios use TICK_DIV=4, GAME_TICKS=3, SCORE_DIGITS=4.
- Reset then idle: `state`=0, `status_row`=40'hFF_FFFF_FFFF, and no `tick` for 20 cycles.
- Normal game: en pulse at cycle 0 → PLAY at 1, ticks at cycles 4, 8 and 12; `time_left` goes 3→2→1→0; `finished`=1 from cycle 13. The row in PLAY reads tiles 0,3,DARK,DARK,0,0,0,0.
- Scoring: hits of 7, 5 and 9 → `score_bcd`=16'h0021. Preload 9995 and add 9 → 9999, then holds at 9999.
- Pause (GAME_PAUSE_EN): pause edge after 2 PLAY cycles, hold 10 cycles, pause edge again → first tick lands exactly 4 PLAY cycles after entering PLAY. A hit while PAUSED is ignored.
- Collisions: hit of 4 on the final-tick cycle → score 4 and FINISH. A pause edge on the final tick → FINISH. en_rise during PLAY → no restart.
- Restart and mid-game reset: en in FINISH → score 0, `time_left` 3, PLAY. `rst` asserted mid-PLAY → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller and its helpers.
// Holds the FSM state encoding, the tile code constants and a digit-to-tile helper.
// No logic of its own; no latency, no backpressure.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAUSED = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int TILE_W = 5;

    localparam logic [TILE_W-1:0] TILE_DARK   = 5'd31;
    localparam logic [TILE_W-1:0] TILE_DIGIT0 = 5'd0;

    // Tile code for a decimal digit 0..9.
    function automatic logic [TILE_W-1:0] digit_tile(input logic [3:0] d);
        return TILE_DIGIT0 + {1'b0, d};
    endfunction

endpackage

// File: rtl/bcd_accum.sv
// Saturating BCD accumulator: adds a single 0..9 value per cycle with a ripple carry.
// Latency: result visible one clock after add_vld/clr; any overflow loads all nines.
// Backpressure: none, one add accepted every cycle add_vld is high.
//
// Ports: clk, rst (sync, active high), clr (sync clear), add_vld/add_val (value 0..9,
//        caller clamps), value (DIGITS BCD digits, least significant digit lowest).
module bcd_accum #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  add_vld,
    input  logic [3:0]            add_val,
    output logic [4*DIGITS-1:0]   value
);

    logic [4*DIGITS-1:0] acc_q;
    logic [4*DIGITS-1:0] sum;
    logic [4:0]          digit_sum;
    logic                carry;

    // Digit-serial decimal add; only digit 0 receives the addend, the rest see carries.
    always_comb begin
        sum       = '0;
        digit_sum = '0;
        carry     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_sum = {1'b0, acc_q[4*i +: 4]} + {4'b0, carry}
                      + ((i == 0) ? {1'b0, add_val} : 5'd0);
            if (digit_sum > 5'd9) begin
                sum[4*i +: 4] = 4'(digit_sum - 5'd10);
                carry         = 1'b1;
            end else begin
                sum[4*i +: 4] = digit_sum[3:0];
                carry         = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
        end else if (add_vld) begin
            // A carry out of the top digit means the true total no longer fits.
            acc_q <= carry ? {DIGITS{4'h9}} : sum;
        end
    end

    assign value = acc_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: IDLE -> PLAY -> FINISH (optional PAUSED), tick prescaler,
// countdown timer, saturating BCD score and the status-row tile encoder.
// Latency: state/timer/score update on the edge sampling their cause; status_row is
// combinational from those registers. Backpressure: none, hits are taken every PLAY cycle.
//
// Optional feature macro: GAME_PAUSE_EN builds the pause edge detector and PAUSED state;
// without it, pause is ignored and PAUSED is never entered.
//
// Ports: clk, rst (sync, active high); en/pause level inputs, rising edge acts;
//        hit_valid/hit_pts score event (pts clamped to 9); state, play_en, tick, finished,
//        time_left (binary), score_bcd, status_row (leftmost tile in the MSBs).
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV     = 100_000_000,
    parameter int GAME_TICKS   = 60,
    parameter int SCORE_DIGITS = 4,
    parameter int COLS         = 8,
    parameter int TILE_W       = game_pkg::TILE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       pause,
    input  logic                       hit_valid,
    input  logic [3:0]                 hit_pts,
    output logic [1:0]                 state,
    output logic                       play_en,
    output logic                       tick,
    output logic                       finished,
    output logic [6:0]                 time_left,
    output logic [4*SCORE_DIGITS-1:0]  score_bcd,
    output logic [COLS*TILE_W-1:0]     status_row
);

    localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [6:0]      TIME_INIT = 7'(GAME_TICKS);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [6:0]         time_q;
    logic [6:0]         time_d;

    logic               en_q;
    logic               en_rise;
    logic               pause_rise;
    logic               tick_now;
    logic               final_tick;
    logic               game_start;
    logic               hit_acc;
    logic [3:0]         hit_val;

    // ---------------------------------------------------------------- edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    assign en_rise = en & ~en_q;

`ifdef GAME_PAUSE_EN
    logic pause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause;
        end
    end

    assign pause_rise = pause & ~pause_q;
`else
    logic unused_pause;

    assign unused_pause = pause;
    assign pause_rise   = 1'b0;
`endif

    // Tick fires in the last prescaler count of a PLAY cycle; the final one ends the game.
    assign tick_now   = (state_q == PLAY) && (cnt_q == CNT_LAST);
    assign final_tick = tick_now && (time_q == 7'd1);
    assign game_start = ((state_q == IDLE) || (state_q == FINISH)) && en_rise;

    // ---------------------------------------------------------------- FSM + prescaler + timer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        time_d  = time_q;
        case (state_q)
            IDLE, FINISH: begin
                cnt_d = '0;
                if (en_rise) begin
                    state_d = PLAY;
                    time_d  = TIME_INIT;
                end
            end
            PLAY: begin
                cnt_d = tick_now ? '0 : cnt_q + 1'b1;
                if (tick_now) begin
                    time_d = time_q - 7'd1;
                end
                // The final tick takes priority over a simultaneous pause edge.
                if (final_tick) begin
                    state_d = FINISH;
                end else if (pause_rise) begin
                    state_d = PAUSED;
                end
            end
`ifdef GAME_PAUSE_EN
            PAUSED: begin
                // Prescaler holds so paused time does not count toward the game.
                if (pause_rise) begin
                    state_d = PLAY;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            time_q  <= TIME_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            time_q  <= time_d;
        end
    end

    // ---------------------------------------------------------------- score
    // Hits count in any PLAY cycle, including the one carrying the final tick.
    assign hit_acc = hit_valid && (state_q == PLAY);
    assign hit_val = (hit_pts > 4'd9) ? 4'd9 : hit_pts;

    bcd_accum #(
        .DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk     (clk),
        .rst     (rst),
        .clr     (game_start),
        .add_vld (hit_acc),
        .add_val (hit_val),
        .value   (score_bcd)
    );

    // ---------------------------------------------------------------- outputs
    assign state     = state_q;
    assign play_en   = (state_q == PLAY);
    assign finished  = (state_q == FINISH);
    assign tick      = tick_now;
    assign time_left = time_q;

    // Row: tile k sits at bits [(COLS-1-k)*TILE_W +: TILE_W]; score digit i at tile COLS-1-i.
    always_comb begin
        status_row = '0;
        for (int k = 0; k < COLS; k++) begin
            status_row[k*TILE_W +: TILE_W] = TILE_W'(TILE_DARK);
        end
        if (state_q != IDLE) begin
            status_row[(COLS-1)*TILE_W +: TILE_W] = TILE_W'(digit_tile(4'(time_q / 7'd10)));
            status_row[(COLS-2)*TILE_W +: TILE_W] = TILE_W'(digit_tile(4'(time_q % 7'd10)));
            for (int i = 0; i < SCORE_DIGITS; i++) begin
                status_row[i*TILE_W +: TILE_W] = TILE_W'(digit_tile(score_bcd[4*i +: 4]));
            end
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

    localparam int TD   = 4;
    localparam int GT   = 3;
    localparam int SD   = 4;
    localparam int NC   = 8;
    localparam int TW   = 5;
    localparam int MAXS = 9999;

    logic         clk;
    logic         rst;
    logic         en;
    logic         pause;
    logic         hit_valid;
    logic [3:0]   hit_pts;
    logic [1:0]   state;
    logic         play_en;
    logic         tick;
    logic         finished;
    logic [6:0]   time_left;
    logic [15:0]  score_bcd;
    logic [39:0]  status_row;

    logic         acc_clr;
    logic         acc_vld;
    logic [3:0]   acc_val;
    logic [15:0]  acc_value;

    game_flow_ctrl #(
        .TICK_DIV     (TD),
        .GAME_TICKS   (GT),
        .SCORE_DIGITS (SD),
        .COLS         (NC),
        .TILE_W       (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pause      (pause),
        .hit_valid  (hit_valid),
        .hit_pts    (hit_pts),
        .state      (state),
        .play_en    (play_en),
        .tick       (tick),
        .finished   (finished),
        .time_left  (time_left),
        .score_bcd  (score_bcd),
        .status_row (status_row)
    );

    bcd_accum #(
        .DIGITS (SD)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr),
        .add_vld (acc_vld),
        .add_val (acc_val),
        .value   (acc_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Game progress is tracked as the number of PLAY cycles elapsed in the current game;
    // tick, time and finish are all derived from that count by plain arithmetic.
    typedef struct {
        int          st;
        bit          tck;
        int          tl;
        logic [15:0] sc;
        logic [39:0] row;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;

    int m_st    = 0;
    int m_done  = 0;
    int m_score = 0;
    bit m_pen   = 0;
    bit m_pp    = 0;
    bit m_known = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        int          r;
        b = '0;
        r = v;
        for (int k = 0; k < SD; k++) begin
            b[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    function automatic logic [39:0] row_of(input int st, input int tl, input int sc);
        int          tiles [NC];
        logic [39:0] r;
        int          p;
        for (int t = 0; t < NC; t++) tiles[t] = 31;
        if (st != 0) begin
            tiles[0] = tl / 10;
            tiles[1] = tl % 10;
            p = sc;
            for (int k = 0; k < SD; k++) begin
                tiles[NC-1-k] = p % 10;
                p = p / 10;
            end
        end
        r = '0;
        for (int t = 0; t < NC; t++) r = (r << TW) | 40'(tiles[t]);
        return r;
    endfunction

    // One clock cycle: apply inputs, record what the DUT must show this cycle, advance model.
    task automatic cyc(input logic r, input logic e, input logic p, input logic h,
                       input logic [3:0] pts);
        exp_t x;
        bit   er;
        bit   pr;
        int   add;
        @(posedge clk);
        #1;
        rst       = r;
        en        = e;
        pause     = p;
        hit_valid = h;
        hit_pts   = pts;
        if (m_known) begin
            x.st  = m_st;
            x.tck = (m_st == 1) && ((m_done % TD) == TD - 1);
            x.tl  = GT - m_done / TD;
            x.sc  = to_bcd(m_score);
            x.row = row_of(m_st, x.tl, m_score);
            exp_q.push_back(x);
        end
        if (r) begin
            m_st = 0; m_done = 0; m_score = 0; m_pen = 0; m_pp = 0; m_known = 1;
        end else begin
            er = e && !m_pen;
            pr = p && !m_pp;
`ifndef GAME_PAUSE_EN
            pr = 0;
`endif
            case (m_st)
                0, 3: if (er) begin
                    m_st = 1; m_done = 0; m_score = 0;
                end
                1: begin
                    if (h) begin
                        add = (int'(pts) > 9) ? 9 : int'(pts);
                        m_score = (m_score + add > MAXS) ? MAXS : m_score + add;
                    end
                    m_done++;
                    if (m_done == GT * TD) m_st = 3;
                    else if (pr)           m_st = 2;
                end
                default: if (pr) m_st = 1;
            endcase
            m_pen = e;
            m_pp  = p;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'd0);
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_x = exp_q.pop_front();
                chk("state",      64'(state),      64'(mon_x.st));
                chk("play_en",    64'(play_en),    64'(mon_x.st == 1));
                chk("finished",   64'(finished),   64'(mon_x.st == 3));
                chk("tick",       64'(tick),       64'(mon_x.tck));
                chk("time_left",  64'(time_left),  64'(mon_x.tl));
                chk("score_bcd",  64'(score_bcd),  64'(mon_x.sc));
                chk("status_row", 64'(status_row), 64'(mon_x.row));
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    int acc_m;

    task automatic acc_op(input logic c, input logic v, input logic [3:0] val);
        @(posedge clk);
        #1;
        acc_clr = c;
        acc_vld = v;
        acc_val = val;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pause = 1'b0; hit_valid = 1'b0; hit_pts = 4'd0;
        acc_clr = 1'b0; acc_vld = 1'b0; acc_val = 4'd0;

        // Reset, then idle with stray pause edges and a hit that must be ignored.
        cyc(1, 0, 0, 0, 4'd0);
        cyc(1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 20; i++) cyc(0, 0, (i % 4) == 1, i == 5, 4'd7);

        // Normal game with hits 7, 5, 9.
        cyc(0, 1, 0, 0, 4'd0);
        cyc(0, 0, 0, 0, 4'd0);
        @(negedge clk);
        chk("row_play_start", 64'(status_row), 64'h00_FFF0_0000);
        cyc(0, 0, 0, 1, 4'd7);
        cyc(0, 0, 0, 1, 4'd5);
        cyc(0, 0, 0, 1, 4'd9);
        idle(10);
        @(negedge clk);
        chk("score_game1", 64'(score_bcd), 64'h0021);
        chk("finished_game1", 64'(finished), 64'd1);

        // Restart from FINISH; pause after 2 PLAY cycles, hold, resume; hit while paused.
        cyc(0, 1, 0, 0, 4'd0);
        idle(2);
        cyc(0, 0, 1, 0, 4'd0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, i == 4, 4'd9);
        cyc(0, 0, 1, 0, 4'd0);
        idle(16);

        // Hit of 4 on the final tick; en edge during PLAY must not restart.
        cyc(0, 1, 0, 0, 4'd0);
        for (int i = 1; i <= 11; i++) cyc(0, (i == 4) || (i == 5), 0, 0, 4'd0);
        cyc(0, 0, 0, 1, 4'd4);
        idle(2);
        @(negedge clk);
        chk("score_final_tick_hit", 64'(score_bcd), 64'h0004);
        chk("finished_final_tick_hit", 64'(finished), 64'd1);

        // Pause edge on the final tick: FINISH wins.
        cyc(0, 1, 0, 0, 4'd0);
        idle(11);
        cyc(0, 0, 1, 0, 4'd0);
        idle(2);
        @(negedge clk);
        chk("finished_final_tick_pause", 64'(state), 64'd3);

        // Mid-game reset.
        cyc(0, 1, 0, 1, 4'd3);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 4'd6);
        cyc(1, 0, 0, 1, 4'd6);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 399) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)));
        end
        idle(4);

        // Accumulator saturation, driven directly.
        acc_op(1, 0, 4'd0);
        acc_op(0, 1, 4'd7);
        acc_op(0, 1, 4'd5);
        acc_op(0, 0, 4'd0);
        @(negedge clk);
        chk("acc_12", 64'(acc_value), 64'h0012);
        acc_m = 12;
        for (int i = 0; i < 1109; i++) begin
            acc_op(0, 1, 4'd9);
            acc_m += 9;
        end
        acc_op(0, 1, 4'd2);
        acc_m += 2;
        acc_op(0, 0, 4'd0);
        @(negedge clk);
        chk("acc_preload", 64'(acc_value), 64'(to_bcd(acc_m)));
        chk("acc_9995", 64'(acc_value), 64'h9995);
        acc_op(0, 1, 4'd9);
        acc_op(0, 0, 4'd0);
        @(negedge clk);
        chk("acc_saturate", 64'(acc_value), 64'h9999);
        acc_op(0, 1, 4'd1);
        acc_op(0, 0, 4'd0);
        @(negedge clk);
        chk("acc_hold", 64'(acc_value), 64'h9999);
        acc_op(1, 0, 4'd0);
        acc_op(0, 0, 4'd0);
        @(negedge clk);
        chk("acc_clear", 64'(acc_value), 64'h0000);

        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
